// File: rtl/gen_mux_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gen_mux_pipe_pkg
//  Description : Shared constant helpers for the pipelined 2^N:1 multiplexer.
//                Stage count, per-stage level range and vector counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package gen_mux_pipe_pkg;

  // Integer ceiling division; a zero denominator yields 1 so a bad L does not
  // crash elaboration before the parameter check can report it.
  function automatic int ceil_div(input int num, input int den);
    if (den < 1) return 1;
    return (num + den - 1) / den;
  endfunction

  // First tree level handled by pipeline stage p.
  function automatic int stage_lo(input int p, input int l);
    return p * l;
  endfunction

  // One past the last tree level handled by pipeline stage p.
  function automatic int stage_hi(input int p, input int n, input int l);
    return ((p + 1) * l < n) ? (p + 1) * l : n;
  endfunction

  // Number of partial vectors still alive after 'lvl' levels of reduction.
  function automatic int vec_cnt(input int n, input int lvl);
    return 1 << (n - lvl);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gen_mux_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : gen_mux_pipe_if
//  Description : Sample/result bundle of the pipelined multiplexer.
//                master : drives valid_in, s, a (and stall); reads valid_out, y
//                slave  : the multiplexer side
//                stall exists only when GEN_MUX_PIPE_STALL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gen_mux_pipe_if #(
  parameter int SIZE = 4,
  parameter int N    = 8
);
  logic                  valid_in;
  logic [N-1:0]          s;
  logic [(SIZE<<N)-1:0]  a;
`ifdef GEN_MUX_PIPE_STALL_EN
  logic                  stall;
`endif
  logic                  valid_out;
  logic [SIZE-1:0]       y;

`ifdef GEN_MUX_PIPE_STALL_EN
  modport master (output valid_in, s, a, stall, input valid_out, y);
  modport slave  (input valid_in, s, a, stall, output valid_out, y);
`else
  modport master (output valid_in, s, a, input valid_out, y);
  modport slave  (input valid_in, s, a, output valid_out, y);
`endif
endinterface
`default_nettype wire

// File: rtl/gen_mux_slice.sv
`default_nettype none
// ============================================================================
//  Module      : gen_mux_slice
//  Description : Combinational block of LEVELS binary mux levels.
//                i_data : IN_CNT linearised vectors, vector k at [k*SIZE +: SIZE]
//                i_sel  : i_sel[j] steers level j (level 0 at the leaves)
//                o_data : IN_CNT >> LEVELS reduced vectors
//  Revision    : 1.0 - initial release
// ============================================================================
module gen_mux_slice
  import gen_mux_pipe_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int IN_CNT = 8,
  parameter int LEVELS = 3
) (
  input  wire logic [SIZE*IN_CNT-1:0]            i_data,
  input  wire logic [LEVELS-1:0]                 i_sel,
  output logic      [SIZE*(IN_CNT>>LEVELS)-1:0]  o_data
);

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int c_NI = IN_CNT >> j;
    localparam int c_NO = c_NI / 2;

    logic [SIZE*c_NI-1:0] w_in;
    logic [SIZE*c_NO-1:0] w_out;

    if (j == 0) begin : g_leaf
      assign w_in = i_data;
    end else begin : g_mid
      assign w_in = g_lvl[j-1].w_out;
    end

    // Adjacent pairs (2k, 2k+1) collapse into vector k of the next level.
    for (genvar k = 0; k < c_NO; k++) begin : g_pair
      mux2to1 #(.SIZE(SIZE)) u_mux (
        .i_d0  (w_in[(2*k)*SIZE +: SIZE]),
        .i_d1  (w_in[(2*k+1)*SIZE +: SIZE]),
        .i_sel (i_sel[j]),
        .o_y   (w_out[k*SIZE +: SIZE])
      );
    end
  end

  assign o_data = g_lvl[LEVELS-1].w_out;

endmodule
`default_nettype wire

// File: rtl/mux2to1.sv
`default_nettype none
// ============================================================================
//  Module      : mux2to1
//  Description : Leaf 2:1 vector multiplexer.
//                i_d0/i_d1 : candidate vectors, i_sel : picks i_d1 when 1,
//                o_y : selected vector
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2to1 #(
  parameter int SIZE = 4
) (
  input  wire logic [SIZE-1:0] i_d0,
  input  wire logic [SIZE-1:0] i_d1,
  input  wire logic            i_sel,
  output logic      [SIZE-1:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule
`default_nettype wire

// File: rtl/gen_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : gen_mux_pipe
//  Description : Pipelined 2^N:1 multiplexer. A register bank follows every L
//                mux levels, giving a latency of ceil(N/L) cycles at one
//                selection per cycle. A valid bit travels with the data.
//                clock : rising-edge clock
//                reset : synchronous, active-high; clears every stage
//                bus   : slave side of gen_mux_pipe_if (valid_in/s/a in,
//                        valid_out/y out, optional stall in)
//                Optional feature macro: GEN_MUX_PIPE_STALL_EN adds a stall
//                input that freezes every pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module gen_mux_pipe
  import gen_mux_pipe_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int N    = 8,
  parameter int L    = 3
) (
  input  wire logic     clock,
  input  wire logic     reset,
  gen_mux_pipe_if.slave bus
);

  localparam int c_P = ceil_div(N, L);

  if (N < 1 || L < 1) begin : g_param_err
    $error("gen_mux_pipe: N and L must both be >= 1");
  end

  // Pipeline advance enable; with the stall feature absent it is always on.
  logic w_adv;
`ifdef GEN_MUX_PIPE_STALL_EN
  assign w_adv = ~bus.stall;
`else
  assign w_adv = 1'b1;
`endif

  for (genvar p = 0; p < c_P; p++) begin : g_stage
    localparam int c_LO    = stage_lo(p, L);
    localparam int c_HI    = stage_hi(p, N, L);
    localparam int c_LV    = c_HI - c_LO;
    localparam int c_IN_W  = SIZE * vec_cnt(N, c_LO);
    localparam int c_OUT_W = SIZE * vec_cnt(N, c_HI);
    localparam int c_SIN_W = N - c_LO;

    logic [c_IN_W-1:0]  w_din;
    logic [c_SIN_W-1:0] w_sin;
    logic               w_vin;
    logic [c_OUT_W-1:0] w_dout;
    logic [c_OUT_W-1:0] r_data;
    logic               r_valid;

    if (p == 0) begin : g_head
      assign w_din = bus.a;
      assign w_sin = bus.s;
      assign w_vin = bus.valid_in;
    end else begin : g_link
      assign w_din = g_stage[p-1].r_data;
      assign w_sin = g_stage[p-1].g_sel.r_sel;
      assign w_vin = g_stage[p-1].r_valid;
    end

    gen_mux_slice #(
      .SIZE   (SIZE),
      .IN_CNT (vec_cnt(N, c_LO)),
      .LEVELS (c_LV)
    ) u_slice (
      .i_data (w_din),
      .i_sel  (w_sin[c_LV-1:0]),
      .o_data (w_dout)
    );

    // Valid follows every advancing edge so bubbles propagate too.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_valid <= w_vin;
      end
    end

    // Data only loads on a valid sample, so the output stage holds the last
    // valid result across bubbles.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_data <= '0;
      end else if (w_adv && w_vin) begin
        r_data <= w_dout;
      end
    end

    // Select bits not yet consumed ride along; the final stage has none left.
    if (c_HI < N) begin : g_sel
      logic [N-c_HI-1:0] r_sel;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_sel <= '0;
        end else if (w_adv && w_vin) begin
          r_sel <= w_sin[c_SIN_W-1:c_LV];
        end
      end
    end
  end

  assign bus.y         = g_stage[c_P-1].r_data;
  assign bus.valid_out = g_stage[c_P-1].r_valid;

endmodule
`default_nettype wire
